// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial WIDTH-bit ALU, one operand bit per clock, LSB first
// start/busy/done handshake; result and flags update only on the completing edge.
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [2:0]       op_q, op_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             arith;
  logic             ai, bi, bp;
  logic             sum, c_next, bit_r;
  logic [WIDTH-1:0] res_next;

  // One-bit datapath: b is inverted for SUB so the same adder serves both.
  always_comb begin
    arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    ai     = a_sh_q[0];
    bi     = b_sh_q[0];
    bp     = bi ^ (op_q == OP_SUB);
    sum    = ai ^ bp ^ c_q;
    c_next = (ai & bp) | (c_q & (ai ^ bp));
    case (op_q)
      OP_ADD, OP_SUB: bit_r = sum;
      OP_AND:         bit_r = ai & bi;
      OP_OR:          bit_r = ai | bi;
      OP_XOR:         bit_r = ai ^ bi;
      OP_NAND:        bit_r = ~(ai & bi);
      OP_NOT:         bit_r = ~ai;
      OP_PASS:        bit_r = ai;
      default:        bit_r = 1'b0;
    endcase
    res_next = {bit_r, res_sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        if (arith) c_d = c_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = res_next;
          carry_d  = arith ? c_next : 1'b0;
          zero_d   = (res_next == '0);
        end
      end
      default: begin
        // IDLE and DONE accept a new operation identically.
        if (start) begin
          state_d  = RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          op_d     = op;
          res_sh_d = '0;
          c_d      = (op == OP_SUB);
          cnt_d    = '0;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - randomized scoreboard bench for serial_alu
// Stimulus pushes model results; a negedge monitor pops and compares on done.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry, zero;
  logic [W-1:0] result;

  serial_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    int           k;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] held_res = '0;
  logic         held_c = 1'b0;
  logic         held_z = 1'b0;
  int           busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int unsigned xs, ys, s;
    xs = x; ys = y;
    e.c = 1'b0;
    case (o)
      3'd0: begin s = xs + ys; e.res = W'(s); e.c = (s >= (1 << W)); end
      3'd1: begin e.res = W'(xs - ys); e.c = (xs >= ys); end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = ~(x & y);
      3'd6: e.res = ~x;
      default: e.res = x;
    endcase
    e.z = (e.res == '0);
    e.k = 0;
    return e;
  endfunction

  // Monitor: scoreboard pop on done, plus hold/handshake checks every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_res = '0; held_c = 1'b0; held_z = 1'b0; busy_run = 0;
    end else begin
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("carry", 32'(carry), 32'(e.c));
          chk("zero", 32'(zero), 32'(e.z));
          chk("latency", 32'(cyc - e.k), 32'(W));
          chk("busy_cycles", 32'(busy_run), 32'(W));
          held_res = e.res; held_c = e.c; held_z = e.z;
        end
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        if (result !== held_res || carry !== held_c || zero !== held_z)
          chk("hold_outputs", {result, carry, zero}, {held_res, held_c, held_z});
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = model(o, x, y);
    e.k = cyc + 1;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_done: no done within %0d cycles (cycle %0d)", W + 4, cyc);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_flags", {carry, zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd0, 8'h5A, 8'h3C); wait_done(); @(negedge clk);
    issue(3'd0, 8'hFF, 8'h01); wait_done(); @(negedge clk);
    issue(3'd1, 8'h20, 8'h20); wait_done(); @(negedge clk);
    issue(3'd1, 8'h10, 8'h20); wait_done(); @(negedge clk);
    issue(3'd5, 8'hF0, 8'hCC); wait_done(); @(negedge clk);
    issue(3'd6, 8'hA5, 8'h00); wait_done(); @(negedge clk);

    // Start pulse during RUN must be ignored; then a back-to-back start in DONE.
    issue(3'd0, 8'h01, 8'h01);
    @(negedge clk); @(negedge clk);
    start = 1'b1; op = 3'd1; a = 8'h09; b = 8'h03;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(3'd1, 8'h09, 8'h03);
    wait_done(); @(negedge clk);

    // Mid-operation reset aborts with no done pulse.
    issue(3'd0, 8'h12, 8'h34);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_flags", {done, carry, zero}, 0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd4, 8'h0F, 8'hFF); wait_done(); @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      wait_done();
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
